// File: rtl/fir_coef_mac.sv
// Serial FIR engine: one coefficient fetch per tap from a registered ROM, 40-bit MAC,
// Q1.15 scaling with saturation. Define FIR_ROUND_EN for round-half-up instead of floor.
module fir_coef_mac #(
   parameter int TAPS   = 60,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic [ADDR_W-1:0]        coef_addr,
   input  logic signed [DATA_W-1:0] coef_q,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data
);

   // state   | meaning
   // S_IDLE  | waiting for a sample, in_ready high
   // S_RUN   | issuing coef_addr 0..TAPS-1, one per cycle
   // S_DRAIN | absorbing the last ROM return
   // S_OUT   | out_valid strobe, write pointer advances
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

   localparam int PROD_W = 2 * DATA_W;
   localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) << (DATA_W - 1));
`ifdef FIR_ROUND_EN
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (DATA_W - 2);
`else
   localparam logic signed [ACC_W-1:0] RND = '0;
`endif

   state_t                     state, state_nxt;
   logic [5:0]                 wp;
   logic [5:0]                 rd_idx;
   logic signed [DATA_W-1:0]   hist [64];
   logic signed [DATA_W-1:0]   hist_rd;
   logic                       mac_en;
   logic                       last_tap;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    acc_sum;
   logic signed [ACC_W-1:0]    acc_shift;
   logic signed [PROD_W-1:0]   prod;
   logic signed [DATA_W-1:0]   sat_val;

   assign last_tap  = (coef_addr == ADDR_W'(TAPS - 1));
   assign rd_idx    = wp - 6'(coef_addr);
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_OUT);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid) state_nxt = S_RUN;
         S_RUN:   if (last_tap) state_nxt = S_DRAIN;
         S_DRAIN: state_nxt = S_OUT;
         S_OUT:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // hist_rd and mac_en lag the address by one cycle so they line up with coef_q
   always_comb begin
      prod      = coef_q * hist_rd;
      acc_sum   = acc + $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
      acc_shift = (acc_sum + RND) >>> (DATA_W - 1);
      sat_val   = acc_shift[DATA_W-1:0];
      if (acc_shift > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
      else if (acc_shift < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wp        <= '0;
         acc       <= '0;
         coef_addr <= '0;
         hist_rd   <= '0;
         mac_en    <= 1'b0;
         out_data  <= '0;
         for (int i = 0; i < 64; i++) hist[i] <= '0;
      end else begin
         mac_en <= (state == S_RUN);
         if (state == S_RUN) hist_rd <= hist[rd_idx];
         if (mac_en) acc <= acc_sum;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  hist[wp]  <= in_data;
                  acc       <= '0;
                  coef_addr <= '0;
               end
            end
            S_RUN:   if (!last_tap) coef_addr <= coef_addr + ADDR_W'(1);
            S_DRAIN: out_data <= sat_val;
            S_OUT:   wp <= wp + 6'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/fir_coef_mac.md
# fir_coef_mac

Serial FIR engine for the lowpass datapath. It reads its coefficients from the registered coefficient ROM, one address per cycle. For each accepted input sample it runs one coefficient fetch per tap against a circular history of past samples, accumulates the products, and emits one scaled and saturated output sample. It drives the ROM's address port and consumes the ROM's `q` port with exactly one cycle of read latency.

## Interface
- `TAPS`, 60: number of taps, legal range 2..64; fetched addresses are 0..TAPS-1.
- `ADDR_W`, 7: coefficient address width; matches the ROM address port.
- `DATA_W`, 16: sample and coefficient width, signed two's complement; coefficients are Q1.15.
- `ACC_W`, 40: accumulator width, signed.
- `clock`  in  1  rising-edge clock shared with the ROM.
- `reset_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input sample is presented.
- `in_ready`  out  1  engine can accept a sample.
- `in_data`  in  DATA_W  signed input sample.
- `coef_addr`  out  ADDR_W  registered address to the ROM.
- `coef_q`  in  DATA_W  ROM data; valid one cycle after `coef_addr`.
- `out_valid`  out  1  one-cycle strobe marking a valid output.
- `out_data`  out  DATA_W  signed filtered sample; holds its value until the next strobe.

## Operation
- **Reset (`reset_n` low):**
  - FSM goes to IDLE; `in_ready`=1, `out_valid`=0, `out_data`=0, `coef_addr`=0.
  - Accumulator and write pointer clear.
  - All 64 history entries clear to 0.
  - Reset applied mid-computation abandons that computation, and no output is produced for it.
- **History:** 64-entry circular buffer with a 6-bit write pointer `wp`.
  - On accept, `in_data` is written at `wp` and `wp` increments after the computation.
  - Tap k pairs `coef[k]` with `hist[(wp_at_accept - k) mod 64]`, where k=0 is the newest sample.
- **FSM:** IDLE → RUN → DRAIN → OUT → IDLE.
  - IDLE: `in_ready`=1. When `in_valid`&&`in_ready`: capture the sample, clear the accumulator, set k=0, go to RUN.
  - RUN: lasts TAPS cycles; `coef_addr`=k and k increments each cycle. After `coef_addr`=TAPS-1, go to DRAIN.
  - DRAIN: 1 cycle; absorbs the final ROM return.
  - OUT: 1 cycle; `out_valid`=1 and `out_data` updates.
- **MAC:**
  - In every cycle where `coef_q` holds a fetched coefficient (RUN cycles 2..TAPS, then DRAIN), `acc += coef_q * hist_aligned`.
  - The product is a 32-bit signed value, sign-extended to ACC_W.
  - The history read index is delayed one cycle so it stays aligned with `coef_q`.
  - `coef_q` during IDLE and the first RUN cycle is ignored.
- **Output scaling:** `out_data` = saturate(acc >>> 15) to [-32768, 32767]. The shift is arithmetic; rounding is covered under Configuration.
- `in_valid` outside IDLE is ignored. Samples are never queued; upstream holds `in_valid` until it is accepted.

## Timing
- Accept at edge A (IDLE).
- `coef_addr`=k is driven during cycle A+1+k, for k=0..TAPS-1.
- `coef_q` for tap k is sampled at the end of cycle A+2+k.
- DRAIN is cycle A+TAPS+1.
- `out_valid` is high for the single cycle A+TAPS+2.
- `in_ready` rises in cycle A+TAPS+3.
- Latency from accept to output is TAPS+2 cycles; throughput is one sample per TAPS+3 cycles (63 at the default).
- `coef_addr` keeps its last value (TAPS-1) through DRAIN, OUT and IDLE until the next accept.
- `out_data` is stable between strobes.

## Configuration
- `FIR_ROUND_EN` defined: add 2^14 to the accumulator before the shift (round half up), then saturate.
- `FIR_ROUND_EN` undefined: plain arithmetic shift (floor), then saturate.
- No other behaviour differs.

## Test plan
- **Impulse, default ROM:** after reset, feed 32767 followed by zeros.
  - Outputs track `coef[k]*32767/32768`: first two outputs are 26, 20 with `FIR_ROUND_EN` and 25, 19 without.
  - The output for the 60th sample uses `coef[59]`=0x001C, giving 28 / 27.
- **Handshake:** hold `in_valid`=1 continuously.
  - Accepts are exactly 63 cycles apart.
  - `out_valid` pulses exactly 62 cycles after each accept.
  - `coef_addr` sweeps 0..59 with no gaps.
- **Saturation:** bench ROM model returning 0x7FFF for every address, TAPS=4.
  - DC input 32767 → `out_data`=32767.
  - DC input -32768 → `out_data`=-32768.
- **Reset mid-operation:** drop `reset_n` while `coef_addr`=30.
  - No `out_valid` appears for that sample, and `in_ready`=1 after release.
  - A following impulse of 32767 reproduces the clean impulse response, confirming the history was cleared.
- **Ignored input:** toggle `in_valid` with random data during RUN.
  - No extra accepts occur.
  - The output equals the value computed without the toggling.
